// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame controller.
// Holds the FSM state encoding, default marker/command bytes and baud limits.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_e;

  localparam int         CLK_FREQ_HZ_DEF = 16_000_000;
  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam logic [7:0] CMD_SETBAUD_DEF = 8'hB0;

  // uart_rx counts clocks per bit in 8 bits, so the divider must stay in 4..255.
  function automatic logic [31:0] baud_min(input int clk_hz);
    return 32'(clk_hz / 255);
  endfunction

  function automatic logic [31:0] baud_max(input int clk_hz);
    return 32'(clk_hz / 4);
  endfunction

  localparam logic [31:0] BAUD_MIN = baud_min(CLK_FREQ_HZ_DEF);
  localparam logic [31:0] BAUD_MAX = baud_max(CLK_FREQ_HZ_DEF);

  function automatic logic baud_ok(input logic [31:0] v,
                                   input logic [31:0] lo,
                                   input logic [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two MAX_LEN x 8 payload banks: one is filled while the other is published.
// A swap flips roles; reads come from the committed bank through a register.
module frame_pingpong_buf import uart_frame_pkg::*; #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic       swap_i,
  input  logic [7:0] rd_addr_i,
  input  logic [7:0] rd_len_i,
  output logic [7:0] rd_data_o
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [7:0] mem_q [2][MAX_LEN];
  logic       bank_q;
  logic [7:0] rd_data_q;
  logic       rd_hit;

  assign rd_hit = (rd_addr_i < rd_len_i) && (rd_addr_i < MAX_LEN_B);

  // Writes always target the shadow bank, so published data stays stable.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && (wr_addr_i < MAX_LEN_B)) begin
      mem_q[~bank_q][wr_addr_i[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q    <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      if (swap_i) begin
        bank_q <= ~bank_q;
      end
      rd_data_q <= rd_hit ? mem_q[bank_q][rd_addr_i[AW-1:0]] : 8'h00;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame assembler behind uart_rx: SYNC, CMD, LEN, PAYLOAD[LEN], CHK.
// Publishes good frames via a ping-pong buffer and handles SETBAUD locally.
module uart_frame_ctrl import uart_frame_pkg::*; #(
  parameter int         CLK_FREQ_HZ  = CLK_FREQ_HZ_DEF,
  parameter int         DEFAULT_BAUD = 115200,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 16000,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter logic [7:0] CMD_SETBAUD  = CMD_SETBAUD_DEF
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic [31:0] o_baudrate,
  output logic        o_Frame_DV,
  output logic [7:0]  o_Cmd,
  output logic [7:0]  o_Len,
  input  logic [7:0]  i_Rd_Addr,
  output logic [7:0]  o_Rd_Data,
  output logic        o_Err_Chk,
  output logic        o_Err_Len,
  output logic        o_Err_Timeout,
  output logic        o_Err_Cfg,
  output logic        o_Busy
);

  localparam int          TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [31:0] BAUD_LO   = baud_min(CLK_FREQ_HZ);
  localparam logic [31:0] BAUD_HI   = baud_max(CLK_FREQ_HZ);
  localparam logic [31:0] BAUD_RST  = 32'(DEFAULT_BAUD);

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    flen_q, flen_d;
  logic [7:0]    idx_q, idx_d;
  logic [31:0]   cfg_q, cfg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   baud_q, baud_d;
  logic [7:0]    ocmd_q, ocmd_d;
  logic [7:0]    olen_q, olen_d;
  logic          fdv_q, fdv_d;
  logic          echk_q, echk_d;
  logic          elen_q, elen_d;
  logic          etmo_q, etmo_d;
  logic          ecfg_q, ecfg_d;
  logic          wr_en;
  logic          swap;
  logic          expire;

  // A byte on the expiry cycle takes priority, hence the !i_Rx_DV term.
  assign expire = (state_q != S_IDLE) && !i_Rx_DV && (tmo_q == TMO_LAST);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 8'h00;
      sum_q   <= 8'h00;
      flen_q  <= 8'h00;
      idx_q   <= 8'h00;
      cfg_q   <= 32'h0;
      tmo_q   <= '0;
      baud_q  <= BAUD_RST;
      ocmd_q  <= 8'h00;
      olen_q  <= 8'h00;
      fdv_q   <= 1'b0;
      echk_q  <= 1'b0;
      elen_q  <= 1'b0;
      etmo_q  <= 1'b0;
      ecfg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sum_q   <= sum_d;
      flen_q  <= flen_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      tmo_q   <= tmo_d;
      baud_q  <= baud_d;
      ocmd_q  <= ocmd_d;
      olen_q  <= olen_d;
      fdv_q   <= fdv_d;
      echk_q  <= echk_d;
      elen_q  <= elen_d;
      etmo_q  <= etmo_d;
      ecfg_q  <= ecfg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    sum_d   = sum_q;
    flen_d  = flen_q;
    idx_d   = idx_q;
    cfg_d   = cfg_q;
    baud_d  = baud_q;
    ocmd_d  = ocmd_q;
    olen_d  = olen_q;
    fdv_d   = 1'b0;
    echk_d  = 1'b0;
    elen_d  = 1'b0;
    etmo_d  = 1'b0;
    ecfg_d  = 1'b0;
    wr_en   = 1'b0;
    swap    = 1'b0;

    if ((state_q == S_IDLE) || i_Rx_DV) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (i_Rx_DV) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_Rx_Byte == SYNC_BYTE) state_d = S_CMD;
        end
        S_CMD: begin
          cmd_d   = i_Rx_Byte;
          sum_d   = i_Rx_Byte;
          state_d = S_LEN;
        end
        S_LEN: begin
          if (i_Rx_Byte > MAX_LEN_B) begin
            elen_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            sum_d   = sum_q + i_Rx_Byte;
            flen_d  = i_Rx_Byte;
            idx_d   = 8'h00;
            cfg_d   = 32'h0;
            state_d = (i_Rx_Byte == 8'h00) ? S_CHK : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          wr_en = 1'b1;
          sum_d = sum_q + i_Rx_Byte;
          idx_d = idx_q + 8'd1;
          // Little-endian shift-in: after four bytes cfg_q holds the 32-bit value.
          cfg_d = {i_Rx_Byte, cfg_q[31:8]};
          if (idx_q == (flen_q - 8'd1)) state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (i_Rx_Byte != sum_q) begin
            echk_d = 1'b1;
          end else if (cmd_q == CMD_SETBAUD) begin
            if ((flen_q == 8'd4) && baud_ok(cfg_q, BAUD_LO, BAUD_HI)) begin
              baud_d = cfg_q;
            end else begin
              ecfg_d = 1'b1;
            end
          end else begin
            swap   = 1'b1;
            ocmd_d = cmd_q;
            olen_d = flen_q;
            fdv_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (expire) begin
      etmo_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  frame_pingpong_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk_i     (i_Clock),
    .rst_i     (i_Reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (idx_q),
    .wr_data_i (i_Rx_Byte),
    .swap_i    (swap),
    .rd_addr_i (i_Rd_Addr),
    .rd_len_i  (olen_q),
    .rd_data_o (o_Rd_Data)
  );

  assign o_baudrate    = baud_q;
  assign o_Frame_DV    = fdv_q;
  assign o_Cmd         = ocmd_q;
  assign o_Len         = olen_q;
  assign o_Err_Chk     = echk_q;
  assign o_Err_Len     = elen_q;
  assign o_Err_Timeout = etmo_q;
  assign o_Err_Cfg     = ecfg_q;
  assign o_Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed cases plus random frames
// compared against a frame-level reference model.
module tb_uart_frame_ctrl;

  localparam int          CLK_HZ   = 16_000_000;
  localparam int          DEF_BAUD = 115200;
  localparam int          MAXL     = 16;
  localparam int          TMO      = 200;
  localparam logic [31:0] B_LO     = 32'd62745;
  localparam logic [31:0] B_HI     = 32'd4000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [7:0]  rd_addr = 8'h00;
  logic [31:0] o_baudrate;
  logic        o_Frame_DV, o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Err_Cfg, o_Busy;
  logic [7:0]  o_Cmd, o_Len, o_Rd_Data;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .DEFAULT_BAUD (DEF_BAUD),
    .MAX_LEN      (MAXL),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .o_baudrate    (o_baudrate),
    .o_Frame_DV    (o_Frame_DV),
    .o_Cmd         (o_Cmd),
    .o_Len         (o_Len),
    .i_Rd_Addr     (rd_addr),
    .o_Rd_Data     (o_Rd_Data),
    .o_Err_Chk     (o_Err_Chk),
    .o_Err_Len     (o_Err_Len),
    .o_Err_Timeout (o_Err_Timeout),
    .o_Err_Cfg     (o_Err_Cfg),
    .o_Busy        (o_Busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observed pulse counts and the counts the model expects.
  int n_fdv = 0, n_chk = 0, n_len = 0, n_tmo = 0, n_cfg = 0;
  int e_fdv = 0, e_chk = 0, e_len = 0, e_tmo = 0, e_cfg = 0;

  // Reference model: what the committed side should look like.
  logic [7:0]  m_bank[$];
  logic [7:0]  m_cmd  = 8'h00;
  int          m_len  = 0;
  logic [31:0] m_baud = DEF_BAUD;
  logic [7:0]  pl_q[$];

  always @(negedge clk) begin
    if (o_Frame_DV)    n_fdv++;
    if (o_Err_Chk)     n_chk++;
    if (o_Err_Len)     n_len++;
    if (o_Err_Timeout) n_tmo++;
    if (o_Err_Cfg)     n_cfg++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gap();
    return $urandom_range(0, 3);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int g);
    repeat (g) tick();
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic fill_rand(input int len);
    pl_q.delete();
    for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic fill_baud(input logic [31:0] v);
    pl_q.delete();
    pl_q.push_back(v[7:0]);
    pl_q.push_back(v[15:8]);
    pl_q.push_back(v[23:16]);
    pl_q.push_back(v[31:24]);
  endtask

  // Sends one frame built from pl_q and checks the outcome the cycle after its last byte.
  task automatic send_frame(input logic [7:0] cmd, input int len, input bit bad);
    logic [7:0]  sum;
    logic [7:0]  cb;
    logic [31:0] v;
    bit          x_fdv, x_chk, x_cfg;
    sum = cmd + 8'(len);
    send_byte(8'hA5, gap());
    send_byte(cmd, gap());
    send_byte(8'(len), gap());
    if (len > MAXL) begin
      e_len++;
      check("len_err_pulse", o_Err_Len, 1);
      check("len_err_no_fdv", o_Frame_DV, 0);
      check("len_err_idle", o_Busy, 0);
      return;
    end
    check("busy_in_frame", o_Busy, 1);
    for (int i = 0; i < len; i++) begin
      send_byte(pl_q[i], gap());
      sum = sum + pl_q[i];
    end
    cb = bad ? sum + 8'($urandom_range(1, 255)) : sum;
    send_byte(cb, gap());
    x_fdv = 0; x_chk = 0; x_cfg = 0;
    if (bad) begin
      x_chk = 1;
    end else if (cmd == 8'hB0) begin
      v = 32'h0;
      if (len == 4) v = {pl_q[3], pl_q[2], pl_q[1], pl_q[0]};
      if (len == 4 && v >= B_LO && v <= B_HI) m_baud = v;
      else x_cfg = 1;
    end else begin
      x_fdv  = 1;
      m_cmd  = cmd;
      m_len  = len;
      m_bank = pl_q;
    end
    e_fdv += int'(x_fdv);
    e_chk += int'(x_chk);
    e_cfg += int'(x_cfg);
    check("frame_dv", o_Frame_DV, x_fdv);
    check("err_chk", o_Err_Chk, x_chk);
    check("err_cfg", o_Err_Cfg, x_cfg);
    check("err_len_quiet", o_Err_Len, 0);
    check("err_tmo_quiet", o_Err_Timeout, 0);
    check("cmd", o_Cmd, m_cmd);
    check("len", o_Len, m_len);
    check("baud", o_baudrate, m_baud);
    check("busy_after", o_Busy, 0);
  endtask

  task automatic rd_check(input int addr);
    logic [7:0] exp;
    rd_addr = 8'(addr);
    tick();
    exp = (addr < m_len && addr < MAXL) ? m_bank[addr] : 8'h00;
    check($sformatf("rd[%0d]", addr), o_Rd_Data, exp);
  endtask

  task automatic check_reads();
    for (int a = 0; a < MAXL + 2; a++) rd_check(a);
    rd_check(255);
  endtask

  task automatic check_counts();
    tick();
    check("cnt_frame_dv", n_fdv, e_fdv);
    check("cnt_err_chk", n_chk, e_chk);
    check("cnt_err_len", n_len, e_len);
    check("cnt_err_tmo", n_tmo, e_tmo);
    check("cnt_err_cfg", n_cfg, e_cfg);
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] v;
    int          kind;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_baud", o_baudrate, DEF_BAUD);
    check("rst_cmd", o_Cmd, 0);
    check("rst_len", o_Len, 0);
    check("rst_rd", o_Rd_Data, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_fdv", o_Frame_DV, 0);
    rst = 1'b0;
    tick();
    check_reads();

    // Basic good frame, then the same frame with a corrupted checksum
    pl_q = '{8'h11, 8'h22};
    send_frame(8'h10, 2, 0);
    check_reads();
    send_frame(8'h10, 2, 1);
    check_reads();
    check_counts();

    // Oversize LEN, trailing zeros ignored in IDLE, then a clean frame
    send_frame(8'h01, 17, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("idle_after_len_err", o_Busy, 0);
    fill_rand(MAXL);
    send_frame(8'h22, MAXL, 0);
    check_reads();
    fill_rand(0);
    send_frame(8'h33, 0, 0);
    check_reads();
    check_counts();

    // Timeout after exactly TMO idle clocks
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    repeat (TMO - 1) tick();
    check("tmo_not_yet", o_Err_Timeout, 0);
    check("tmo_busy_before", o_Busy, 1);
    tick();
    e_tmo++;
    check("tmo_pulse", o_Err_Timeout, 1);
    check("tmo_busy_drop", o_Busy, 0);

    // A byte landing on the expiry cycle wins
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    repeat (TMO - 1) tick();
    send_byte(8'h02, 0);
    check("tmo_suppressed", o_Err_Timeout, 0);
    check("tmo_supp_busy", o_Busy, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 2);
    send_byte(8'h45, 0);
    e_fdv++;
    m_cmd = 8'h10; m_len = 2; m_bank = '{8'h11, 8'h22};
    check("tmo_supp_fdv", o_Frame_DV, 1);
    check_reads();
    check_counts();

    // Baud configuration, including range boundaries and wrong length
    fill_baud(32'd115200);  send_frame(8'hB0, 4, 0);
    fill_baud(32'd100);     send_frame(8'hB0, 4, 0);
    fill_baud(B_LO);        send_frame(8'hB0, 4, 0);
    fill_baud(B_LO - 1);    send_frame(8'hB0, 4, 0);
    fill_baud(B_HI);        send_frame(8'hB0, 4, 0);
    fill_baud(B_HI + 1);    send_frame(8'hB0, 4, 0);
    fill_rand(3);           send_frame(8'hB0, 3, 0);
    fill_baud(32'd230400);  send_frame(8'hB0, 4, 0);
    check_reads();
    check_counts();

    // Reset in the middle of a payload
    rd_addr = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    send_byte(8'h04, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    check("pre_rst_rd", o_Rd_Data, 8'h11);
    rst = 1'b1;
    tick();
    check("mrst_baud", o_baudrate, DEF_BAUD);
    check("mrst_cmd", o_Cmd, 0);
    check("mrst_len", o_Len, 0);
    check("mrst_rd", o_Rd_Data, 0);
    check("mrst_busy", o_Busy, 0);
    check("mrst_pulses", {o_Frame_DV, o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Err_Cfg}, 0);
    rst = 1'b0;
    m_cmd = 8'h00; m_len = 0; m_baud = DEF_BAUD; m_bank.delete();
    tick();
    fill_rand(5);
    send_frame(8'h44, 5, 0);
    check_reads();
    check_counts();

    // Randomized frames with idle-line noise
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, gap());
        check("noise_idle", o_Busy, 0);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_frame(8'($urandom_range(0, 255)), $urandom_range(MAXL + 1, 255), 0);
      end else if (kind <= 2) begin
        if ($urandom_range(0, 1) == 1) v = $urandom_range(int'(B_LO), int'(B_HI));
        else v = $urandom_range(0, int'(B_LO) - 1);
        if ($urandom_range(0, 4) == 0) begin
          fill_rand(5);
          send_frame(8'hB0, 5, 0);
        end else begin
          fill_baud(v);
          send_frame(8'hB0, 4, $urandom_range(0, 5) == 0);
        end
      end else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hB0) b = 8'h10;
        kind = $urandom_range(0, MAXL);
        fill_rand(kind);
        send_frame(b, kind, $urandom_range(0, 3) == 0);
      end
      if (it % 4 == 0) check_reads();
      else rd_check($urandom_range(0, MAXL + 1));
      check_counts();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
